// File: rtl/led_run_checker_pkg.sv
// -----------------------------------------------------------------------------
// led_run_checker_pkg
// Shared definitions for the running-light LED bus checker:
//   - LED bus width, LED index width and error-counter width
//   - FSM state encoding (IDLE / SYNC / TRACK)
//   - step classification between two LED indices (mod-8 wrap)
// -----------------------------------------------------------------------------
package led_run_checker_pkg;

  localparam int unsigned LED_W    = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned ERRCNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STEP_NONE  = 2'd0,
    STEP_LEFT  = 2'd1,
    STEP_RIGHT = 2'd2
  } step_t;

  // Relation of the current index to the previous one. The index width is
  // exactly log2 of the bus width, so the +1/-1 arithmetic wraps 7->0 and
  // 0->7 naturally. A sample that is not one-hot is never a step.
  function automatic step_t classify_step(input logic             oh,
                                          input logic [IDX_W-1:0] prev_idx,
                                          input logic [IDX_W-1:0] idx);
    step_t s;
    s = STEP_NONE;
    if (oh) begin
      if (idx == prev_idx + IDX_W'(1)) begin
        s = STEP_LEFT;
      end else if (idx == prev_idx - IDX_W'(1)) begin
        s = STEP_RIGHT;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/led_run_checker_onehot_enc.sv
// -----------------------------------------------------------------------------
// led_onehot_enc
// Combinational one-hot detector / encoder for the LED bus.
// Ports:
//   bus  in  LED_W  sampled LED bus
//   oh   out 1      exactly one bit of bus is set
//   idx  out IDX_W  index of the set bit (meaningful only when oh = 1)
// -----------------------------------------------------------------------------
module led_onehot_enc
  import led_run_checker_pkg::*;
(
  input  logic [LED_W-1:0] bus,
  output logic             oh,
  output logic [IDX_W-1:0] idx
);

  logic             w_seen;
  logic             w_multi;
  logic [IDX_W-1:0] w_idx;

  // A second set bit marks the bus as multi-hot; no population count needed.
  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      if (bus[i]) begin
        if (w_seen) begin
          w_multi = 1'b1;
        end
        w_seen = 1'b1;
        w_idx  = IDX_W'(i);
      end
    end
  end

  assign oh  = w_seen & ~w_multi;
  assign idx = w_idx;

endmodule

// File: rtl/led_run_checker.sv
// -----------------------------------------------------------------------------
// led_run_checker
// Receiver-side monitor for the 8-bit running-light LED bus. Locks onto a
// single lit LED stepping one position per clock (with wrap-around), reports
// position and direction, and flags stalls, direction reversals and illegal
// steps.
//
// Parameters:
//   STALL_MAX  consecutive unchanged samples in TRACK before stalled (1..255)
// Ports:
//   clk      in  1  rising-edge clock
//   rst      in  1  asynchronous active-high reset
//   led      in  8  observed LED bus, bit 0 = rightmost LED
//   pos      out 3  index of the lit LED
//   dir      out 1  1 = stepping toward MSB, 0 = toward LSB
//   valid    out 1  high while locked (TRACK)
//   stalled  out 1  locked and bus unchanged for >= STALL_MAX samples
//   dir_chg  out 1  one-cycle pulse on a legal reversal
//   err      out 1  one-cycle pulse on an illegal step while locked
//   err_cnt  out 8  saturating count of err pulses
// Build option:
//   LED_RUN_CHECKER_ERRCNT_EN  defined -> 8-bit saturating error counter is
//                              built; undefined -> err_cnt tied to zero.
// -----------------------------------------------------------------------------
module led_run_checker
  import led_run_checker_pkg::*;
#(
  parameter int unsigned STALL_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LED_W-1:0]    led,
  output logic [IDX_W-1:0]    pos,
  output logic                dir,
  output logic                valid,
  output logic                stalled,
  output logic                dir_chg,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int unsigned      CNT_W     = $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0] STALL_SAT = CNT_W'(STALL_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Registered state
  state_t           r_state;
  logic [LED_W-1:0] r_prev;
  logic [IDX_W-1:0] r_pos;
  logic             r_dir;
  logic             r_valid;
  logic             r_stalled;
  logic             r_dir_chg;
  logic             r_err;
  logic [CNT_W-1:0] r_stall_cnt;

  // Combinational
  logic             w_oh;
  logic [IDX_W-1:0] w_idx;
  logic             w_change;
  logic             w_blank;
  step_t            w_step;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_pos_nxt;
  logic             w_dir_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_valid_nxt;
  logic             w_stalled_nxt;
  logic             w_dir_chg_nxt;
  logic             w_err_nxt;

  led_onehot_enc u_enc (
    .bus (led),
    .oh  (w_oh),
    .idx (w_idx)
  );

  assign w_change = (led != r_prev);
  assign w_blank  = (led == '0);
  // r_pos always holds the index of r_prev while in SYNC/TRACK, so it serves
  // as the previous index without a second encoder on r_prev.
  assign w_step   = classify_step(w_oh, r_pos, w_idx);

  // ---------------------------------------------------------------------------
  // State register (plus last-sample register)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_prev  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= led;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_oh) begin
          w_state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (w_change) begin
          w_state_nxt = (w_step != STEP_NONE) ? ST_TRACK : ST_IDLE;
        end
      end
      ST_TRACK: begin
        if (w_change && (w_blank || (w_step == STEP_NONE))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values for the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pos_nxt     = r_pos;
    w_dir_nxt     = r_dir;
    w_cnt_nxt     = r_stall_cnt;
    w_dir_chg_nxt = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_oh) begin
          w_pos_nxt = w_idx;
        end
      end
      ST_SYNC: begin
        if (w_change && (w_step != STEP_NONE)) begin
          w_pos_nxt = w_idx;
          w_dir_nxt = (w_step == STEP_LEFT);
          w_cnt_nxt = '0;
        end
      end
      ST_TRACK: begin
        if (!w_change) begin
          if (r_stall_cnt != STALL_SAT) begin
            w_cnt_nxt = r_stall_cnt + CNT_ONE;
          end
        end else if (w_blank) begin
          // Blank bus: generator in reset or blanked, drop lock silently.
          w_cnt_nxt = '0;
        end else if (w_step != STEP_NONE) begin
          w_pos_nxt = w_idx;
          w_cnt_nxt = '0;
          if ((w_step == STEP_LEFT) != r_dir) begin
            w_dir_nxt     = ~r_dir;
            w_dir_chg_nxt = 1'b1;
          end
        end else begin
          w_err_nxt = 1'b1;
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
    w_valid_nxt   = (w_state_nxt == ST_TRACK);
    w_stalled_nxt = w_valid_nxt && (w_cnt_nxt == STALL_SAT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos       <= '0;
      r_dir       <= 1'b0;
      r_valid     <= 1'b0;
      r_stalled   <= 1'b0;
      r_dir_chg   <= 1'b0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_pos       <= w_pos_nxt;
      r_dir       <= w_dir_nxt;
      r_valid     <= w_valid_nxt;
      r_stalled   <= w_stalled_nxt;
      r_dir_chg   <= w_dir_chg_nxt;
      r_err       <= w_err_nxt;
      r_stall_cnt <= w_cnt_nxt;
    end
  end

  assign pos     = r_pos;
  assign dir     = r_dir;
  assign valid   = r_valid;
  assign stalled = r_stalled;
  assign dir_chg = r_dir_chg;
  assign err     = r_err;

`ifdef LED_RUN_CHECKER_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_err_nxt && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_led_run_checker.sv
// -----------------------------------------------------------------------------
// tb_led_run_checker
// Self-checking bench for led_run_checker: directed scenarios with literal
// expectations, then randomized generator-like traffic checked every cycle
// against a behavioural model.
// -----------------------------------------------------------------------------
module tb_led_run_checker;

  localparam int unsigned SM = 4;
`ifdef LED_RUN_CHECKER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] led = 8'h00;
  logic [2:0] pos;
  logic       dir;
  logic       valid;
  logic       stalled;
  logic       dir_chg;
  logic       err;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  led_run_checker #(.STALL_MAX(SM)) dut (
    .clk     (clk),
    .rst     (rst),
    .led     (led),
    .pos     (pos),
    .dir     (dir),
    .valid   (valid),
    .stalled (stalled),
    .dir_chg (dir_chg),
    .err     (err),
    .err_cnt (err_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase 0 = unlocked, 1 = candidate seen, 2 = locked.
  // Steps are classified by the signed distance between indices mod 8.
  // ---------------------------------------------------------------------------
  int         m_phase = 0;
  logic [7:0] m_prev  = 8'h00;
  int         m_pos   = 0;
  int         m_dir   = 0;
  int         m_still = 0;
  int         m_err   = 0;
  int         m_dchg  = 0;
  int         m_errs  = 0;

  function automatic int onehot_idx(input logic [7:0] v);
    int n = 0;
    int k = -1;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        n++;
        k = i;
      end
    end
    return (n == 1) ? k : -1;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = 0; m_prev = 8'h00; m_pos = 0; m_dir = 0;
      m_still = 0; m_err = 0; m_dchg = 0; m_errs = 0;
    end else begin
      int  k;
      int  d;
      bit  chg;
      k      = onehot_idx(led);
      d      = (k >= 0) ? ((k - m_pos + 8) % 8) : 0;
      chg    = (led != m_prev);
      m_err  = 0;
      m_dchg = 0;
      case (m_phase)
        0: if (k >= 0) begin m_phase = 1; m_pos = k; end
        1: if (chg) begin
             if (k >= 0 && (d == 1 || d == 7)) begin
               m_phase = 2; m_dir = (d == 1) ? 1 : 0; m_pos = k; m_still = 0;
             end else begin
               m_phase = 0;
             end
           end
        default: begin
          if (!chg) begin
            m_still++;
          end else if (led == 8'h00) begin
            m_phase = 0;
          end else if (k >= 0 && (d == 1 || d == 7)) begin
            if (((d == 1) ? 1 : 0) != m_dir) begin
              m_dir  = (d == 1) ? 1 : 0;
              m_dchg = 1;
            end
            m_pos   = k;
            m_still = 0;
          end else begin
            m_err = 1;
            if (m_errs < 255) m_errs++;
            m_phase = 0;
          end
        end
      endcase
      m_prev = led;
    end
  end

  // Compare process: every negedge outside reset.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("valid",   int'(valid),   (m_phase == 2) ? 1 : 0);
      chk("pos",     int'(pos),     m_pos);
      chk("dir",     int'(dir),     m_dir);
      chk("stalled", int'(stalled), (m_phase == 2 && m_still >= int'(SM)) ? 1 : 0);
      chk("dir_chg", int'(dir_chg), m_dchg);
      chk("err",     int'(err),     m_err);
      chk("err_cnt", int'(err_cnt), CNT_EN ? m_errs : 0);
      chk("excl",    int'(err & dir_chg), 0);
    end
  end

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    led = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bit_of(input int p);
    return 8'(1 << ((p % 8 + 8) % 8));
  endfunction

  initial begin
    int gp;
    int gdir;
    int r;
    logic [7:0] v;

    // Reset for two cycles.
    rst = 1'b1;
    led = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_valid",  int'(valid),   0);
    chk("rst_pos",    int'(pos),     0);
    chk("rst_dir",    int'(dir),     0);
    chk("rst_errcnt", int'(err_cnt), 0);

    // Lock left.
    drive(8'h01);
    chk("lock_v0", int'(valid), 0);
    drive(8'h02);
    chk("lock_v1",   int'(valid), 1);
    chk("lock_dir",  int'(dir),   1);
    chk("lock_pos1", int'(pos),   1);
    chk("model_pos1", m_pos, 1);
    drive(8'h04);
    chk("lock_pos2", int'(pos), 2);

    // Stall: 08 is a step, then four unchanged samples.
    drive(8'h08);
    drive(8'h08);
    drive(8'h08);
    drive(8'h08);
    chk("stall_3", int'(stalled), 0);
    drive(8'h08);
    chk("stall_4", int'(stalled), 1);
    chk("model_stall", (m_still >= int'(SM)) ? 1 : 0, 1);
    drive(8'h10);
    chk("unstall",     int'(stalled), 0);
    chk("unstall_pos", int'(pos),     4);

    // Reversal.
    drive(8'h08);
    chk("rev_pulse", int'(dir_chg), 1);
    chk("rev_dir",   int'(dir),     0);
    chk("rev_pos",   int'(pos),     3);
    chk("rev_valid", int'(valid),   1);
    drive(8'h04);
    chk("rev_end", int'(dir_chg), 0);

    // Illegal jump, then multi-hot while unlocked.
    drive(8'h20);
    chk("ill_err",    int'(err),     1);
    chk("ill_valid",  int'(valid),   0);
    chk("ill_errcnt", int'(err_cnt), CNT_EN ? 1 : 0);
    drive(8'h0C);
    chk("mh_err", int'(err), 0);

    // Left wrap 80 -> 01.
    drive(8'h00);
    drive(8'h40);
    drive(8'h80);
    chk("wl_pos7", int'(pos), 7);
    drive(8'h01);
    chk("wl_pos0", int'(pos),   0);
    chk("wl_err",  int'(err),   0);
    chk("wl_val",  int'(valid), 1);

    // Walk right down to 01, then wrap to 80.
    for (int p = 7; p >= 0; p--) drive(bit_of(p));
    chk("wr_dir", int'(dir), 0);
    drive(8'h80);
    chk("wr_pos", int'(pos),     7);
    chk("wr_err", int'(err),     0);
    chk("wr_chg", int'(dir_chg), 0);

    // Asynchronous reset between edges while locked.
    drive(8'h40);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid",  int'(valid),   0);
    chk("ar_pos",    int'(pos),     0);
    chk("ar_dir",    int'(dir),     0);
    chk("ar_stall",  int'(stalled), 0);
    chk("ar_errcnt", int'(err_cnt), 0);
    led = 8'h00;
    @(negedge clk);
    #2 rst = 1'b0;

    // Randomized generator-like traffic.
    gp   = 0;
    gdir = 1;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        gp = (gp + (gdir != 0 ? 1 : 7)) % 8;
        drive(bit_of(gp));
      end else if (r < 78) begin
        repeat ($urandom_range(1, 7)) drive(bit_of(gp));
      end else if (r < 84) begin
        gdir = 1 - gdir;
        gp = (gp + (gdir != 0 ? 1 : 7)) % 8;
        drive(bit_of(gp));
      end else if (r < 88) begin
        drive(8'h00);
      end else if (r < 93) begin
        gp = (gp + int'($urandom_range(2, 6))) % 8;
        drive(bit_of(gp));
      end else if (r < 96) begin
        v = 8'($urandom);
        drive(v);
      end else if (r < 99) begin
        drive(bit_of(gp) | bit_of(gp + 3));
      end else begin
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rr_valid", int'(valid), 0);
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
